uart_tx_fifo_top: RTL and testbench

Parametrised UART transmitter: the next generation of the single-byte UART TX top. It adds a configurable data width, a runtime-selectable stop-bit count, a valid/ready input handshake in front of a small word FIFO, and a baud-tick enable so bit timing is decoupled from the system clock. It sits between the system's register/control path and the serial pin, and sends back-to-back frames with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx_word_fifo.sv | 57 +++++
 rtl/uart_tx_fifo_top.sv | 141 ++++++++++++++
 tb/tb_uart_tx_fifo_top.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the FIFO-fed UART transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_tx_word_fifo.sv
// Small word FIFO in front of the UART framer; head word readable combinationally.
// Latency: a word pushed at edge N is poppable from edge N+1 (no bypass).
// Backpressure: push ignored while full, even if a pop happens in the same cycle.
// Ports: push/wdata write side, pop/rdata read side, full/empty/count status.
module uart_tx_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_top.sv
// UART transmitter fed by a word FIFO; width, parity and stop bits configurable.
// Latency: word accepted at E0 is popped at E1 (tick high) with start bit visible after E1.
// Backpressure: in_ready = !full; frames run back-to-back while the FIFO holds data.
// Ports: clk/rst, tx_tick baud strobe, in_data/in_valid/in_ready push side,
//        par_en/par_typ/stop2 frame config, tx_out line, busy/frame_done/fifo_count status.
module uart_tx_fifo_top
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_tick,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          par_en,
  input  logic                          par_typ,
  input  logic                          stop2,
  output logic                          tx_out,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  tx_state_e             state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_acc;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stop2_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  frame_end;
  logic                  pop;

  assign in_ready = !fifo_full;

  // Last stop state is ending on this tick.
  assign frame_end = tx_tick && ((state == STOP1 && !stop2_q) || state == STOP2);
  // Pop from idle or straight out of the final stop bit, so frames chain with no gap.
  assign pop = tx_tick && !fifo_empty && (state == IDLE || frame_end);

  uart_tx_word_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Parity accumulates as each data bit is put on the line; the odd/even
  // selection is applied when the parity bit is emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      stop2_q    <= 1'b0;
      tx_out     <= STOP_BIT;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (pop) begin
        state     <= START;
        busy      <= 1'b1;
        tx_out    <= START_BIT;
        shreg     <= fifo_rdata;
        par_acc   <= 1'b0;
        par_en_q  <= par_en;
        par_typ_q <= par_typ;
        stop2_q   <= stop2;
      end else if (tx_tick) begin
        case (state)
          IDLE: begin
            tx_out <= STOP_BIT;
          end
          START: begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_out  <= shreg[0];
            par_acc <= par_acc ^ shreg[0];
            shreg   <= {1'b0, shreg[DATA_WIDTH-1:1]};
          end
          DATA: begin
            if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              if (par_en_q) begin
                state  <= PARITY;
                tx_out <= par_acc ^ par_typ_q;
              end else begin
                state  <= STOP1;
                tx_out <= STOP_BIT;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              tx_out  <= shreg[0];
              par_acc <= par_acc ^ shreg[0];
              shreg   <= {1'b0, shreg[DATA_WIDTH-1:1]};
            end
          end
          PARITY: begin
            state  <= STOP1;
            tx_out <= STOP_BIT;
          end
          STOP1: begin
            tx_out <= STOP_BIT;
            if (stop2_q) begin
              state <= STOP2;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            busy   <= 1'b0;
            tx_out <= STOP_BIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_top.sv
module tb_uart_tx_fifo_top;

  logic clk;
  logic rst;

  logic       a_tick, a_valid, a_ready, a_par_en, a_par_typ, a_stop2;
  logic [7:0] a_data;
  logic       a_tx, a_busy, a_done;
  logic [2:0] a_count;

  logic       b_tick, b_valid, b_ready, b_par_en, b_par_typ, b_stop2;
  logic [4:0] b_data;
  logic       b_tx, b_busy, b_done;
  logic [2:0] b_count;

  int errors;
  int checks;

  uart_tx_fifo_top #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .tx_tick(a_tick), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .par_en(a_par_en), .par_typ(a_par_typ), .stop2(a_stop2),
    .tx_out(a_tx), .busy(a_busy), .frame_done(a_done), .fifo_count(a_count)
  );

  uart_tx_fifo_top #(.DATA_WIDTH(5), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .tx_tick(b_tick), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .par_en(b_par_en), .par_typ(b_par_typ), .stop2(b_stop2),
    .tx_out(b_tx), .busy(b_busy), .frame_done(b_done), .fifo_count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_done !== 1'b0 || a_count !== 3'd0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: tx=%b busy=%b done=%b count=%0d ready=%b, expected 1 0 0 0 1",
               a_tx, a_busy, a_done, a_count, a_ready);
    end
    checks++;
    if (b_tx !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0 || b_count !== 3'd0 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_b: tx=%b busy=%b done=%b count=%0d ready=%b, expected 1 0 0 0 1",
               b_tx, b_busy, b_done, b_count, b_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_8e1();
    logic [0:10] e;
    e = 11'b01010010101;
    a_par_en = 1'b1; a_par_typ = 1'b0; a_stop2 = 1'b0; a_tick = 1'b1;
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'hA5;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checks++;
      if (a_tx !== e[i] || a_busy !== 1'b1 || a_done !== 1'b0) begin
        errors++;
        $display("FAIL basic_8e1 bit %0d: tx=%b busy=%b done=%b, expected tx=%b busy=1 done=0",
                 i, a_tx, a_busy, a_done, e[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_tx !== 1'b1) begin
      errors++;
      $display("FAIL basic_8e1 end: done=%b busy=%b tx=%b, expected 1 0 1", a_done, a_busy, a_tx);
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_8e1 done_pulse: done=%b, expected 0", a_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [0:23] e;
    e = 24'b000000000111011111111111;
    a_par_en = 1'b1; a_par_typ = 1'b1; a_stop2 = 1'b1; a_tick = 1'b1;
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'h00;
    @(negedge clk);
    a_data = 8'hFF;
    @(negedge clk);
    a_valid = 1'b0;
    checks++;
    if (a_count !== 3'd1) begin
      errors++;
      $display("FAIL push_pop_count: count=%0d, expected 1", a_count);
    end
    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (a_tx !== e[i] || a_busy !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back bit %0d: tx=%b busy=%b, expected tx=%b busy=1", i, a_tx, a_busy, e[i]);
      end
      if (i == 12) begin
        checks++;
        if (a_done !== 1'b1) begin
          errors++;
          $display("FAIL back_to_back done1: done=%b, expected 1", a_done);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back end: done=%b busy=%b, expected 1 0", a_done, a_busy);
    end
  endtask

  task automatic test_full_fifo();
    logic [0:39] cap;
    logic [7:0]  got;
    logic [7:0]  exp_b;
    a_par_en = 1'b0; a_stop2 = 1'b0; a_par_typ = 1'b0; a_tick = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (a_ready !== (k < 4)) begin
        errors++;
        $display("FAIL full_ready before push %0d: ready=%b, expected %b", k, a_ready, (k < 4));
      end
      a_valid = 1'b1;
      a_data  = 8'h11 + 8'(k);
    end
    @(negedge clk);
    a_valid = 1'b0;
    checks++;
    if (a_count !== 3'd4 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_count: count=%0d ready=%b, expected 4 0", a_count, a_ready);
    end
    a_tick = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cap[i] = a_tx;
    end
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) got[j] = cap[k*10+1+j];
      exp_b = 8'h11 + 8'(k);
      checks++;
      if (cap[k*10] !== 1'b0 || got !== exp_b || cap[k*10+9] !== 1'b1) begin
        errors++;
        $display("FAIL full_frame %0d: start=%b data=%h stop=%b, expected 0 %h 1",
                 k, cap[k*10], got, cap[k*10+9], exp_b);
      end
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_count !== 3'd0) begin
      errors++;
      $display("FAIL full_end: done=%b busy=%b count=%0d, expected 1 0 0", a_done, a_busy, a_count);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (a_tx !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL full_no_fifth: tx=%b busy=%b, expected 1 0", a_tx, a_busy);
    end
  endtask

  task automatic test_narrow_slow();
    logic [0:6] e;
    e = 7'b0110011;
    b_par_en = 1'b0; b_par_typ = 1'b0; b_stop2 = 1'b0; b_tick = 1'b0;
    @(negedge clk);
    b_valid = 1'b1; b_data = 5'h13;
    @(negedge clk);
    b_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      if (c >= 1 && c <= 28) begin
        checks++;
        if (b_tx !== e[(c-1)/4]) begin
          errors++;
          $display("FAIL narrow cycle %0d: tx=%b, expected %b", c, b_tx, e[(c-1)/4]);
        end
      end
      if (c == 29) begin
        checks++;
        if (b_done !== 1'b1 || b_busy !== 1'b0) begin
          errors++;
          $display("FAIL narrow end: done=%b busy=%b, expected 1 0", b_done, b_busy);
        end
      end
      b_tick = (c % 4 == 0) && (c <= 28);
    end
    b_tick = 1'b0;
  endtask

  task automatic test_config_change();
    logic [0:21] e;
    e = 22'b0001111001011000011011;
    a_par_en = 1'b0; a_stop2 = 1'b0; a_par_typ = 1'b0; a_tick = 1'b1;
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'h3C;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      checks++;
      if (a_tx !== e[i]) begin
        errors++;
        $display("FAIL config_change bit %0d: tx=%b, expected %b", i, a_tx, e[i]);
      end
      if (i == 3) begin
        a_par_en = 1'b1; a_stop2 = 1'b1;
        a_valid = 1'b1; a_data = 8'hC3;
      end
      if (i == 4) a_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1) begin
      errors++;
      $display("FAIL config_change end: done=%b, expected 1", a_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [0:9] e;
    e = 10'b0100000011;
    a_par_en = 1'b0; a_stop2 = 1'b0; a_par_typ = 1'b0; a_tick = 1'b1;
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'h55;
    @(negedge clk);
    a_data = 8'h66;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (a_tx !== 1'b0 || a_busy !== 1'b1 || a_count !== 3'd1) begin
      errors++;
      $display("FAIL pre_reset: tx=%b busy=%b count=%0d, expected 0 1 1", a_tx, a_busy, a_count);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_count !== 3'd0 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: tx=%b busy=%b count=%0d ready=%b, expected 1 0 0 1",
               a_tx, a_busy, a_count, a_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'h81;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (a_tx !== e[i]) begin
        errors++;
        $display("FAIL after_reset bit %0d: tx=%b, expected %b", i, a_tx, e[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset end: done=%b busy=%b, expected 1 0", a_done, a_busy);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    a_tick = 1'b0; a_valid = 1'b0; a_data = '0; a_par_en = 1'b0; a_par_typ = 1'b0; a_stop2 = 1'b0;
    b_tick = 1'b0; b_valid = 1'b0; b_data = '0; b_par_en = 1'b0; b_par_typ = 1'b0; b_stop2 = 1'b0;
    test_reset();
    test_basic_8e1();
    test_back_to_back();
    test_full_fifo();
    test_narrow_slow();
    test_config_change();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
